// File: rtl/gvizi_pkg.sv
// Shared types for the gvizi pulse stretcher.
// Channel FSM states and the default channel count.
package gvizi_pkg;

    localparam int NCH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } ch_state_t;

endpackage

// File: rtl/stretch_channel.sv
// One stretcher channel: synchronizer, edge detect, FSM,
// width/holdoff counters, LED on-time timer and overrun flag.
module stretch_channel
    import gvizi_pkg::*;
#(
    parameter int WW        = 16,
    parameter int LED_TICKS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          en,
    input  logic          pulse_in,
    input  logic [WW-1:0] width,
    input  logic [7:0]    holdoff,
    input  logic          clr_err,
    output logic          pulse_out,
    output logic          led_out,
    output logic          busy,
    output logic          overrun
);

    localparam int LW = $clog2(LED_TICKS + 1);
    localparam logic [LW-1:0] LED_LOAD = LW'(LED_TICKS);

    logic [2:0]    sync_q;
    logic [1:0]    fill_q;
    logic          armed_q;
    logic          edge_det;
    logic          trig;
    ch_state_t     state_q;
    logic [WW-1:0] cnt_q;
    logic [7:0]    hold_q;
    logic [LW-1:0] led_cnt_q;

    // armed_q blocks a level that was already high across reset
    assign edge_det = sync_q[1] & ~sync_q[2] & armed_q;
    assign trig     = edge_det & en & (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], pulse_in};
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & ~sync_q[1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            pulse_out <= 1'b0;
        end else if (!en) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            pulse_out <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q   <= ACTIVE;
                        cnt_q     <= (width == '0) ? '0 : width - WW'(1);
                        hold_q    <= holdoff;
                        pulse_out <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cnt_q == '0) begin
                        pulse_out <= 1'b0;
                        if (hold_q == 8'd0) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= HOLDOFF;
                            hold_q  <= hold_q - 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - WW'(1);
                    end
                end
                HOLDOFF: begin
                    if (hold_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q - 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pulse_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_cnt_q <= '0;
            led_out   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // a fresh overrun outranks a same-cycle clear
            overrun <= (overrun & ~clr_err) | (edge_det & en & busy);
            if (!en) begin
                led_cnt_q <= '0;
                led_out   <= 1'b0;
            end else if (trig) begin
                led_cnt_q <= LED_LOAD;
                led_out   <= 1'b1;
            end else if (tick && led_cnt_q != '0) begin
                led_cnt_q <= led_cnt_q - LW'(1);
                led_out   <= (led_cnt_q != LW'(1));
            end
        end
    end

endmodule

// File: rtl/gvizi_pulse_stretcher.sv
// Multi-channel pulse stretcher with LED drive and overrun flags.
// One stretch_channel per channel, sharing width/holdoff/tick.
module gvizi_pulse_stretcher
    import gvizi_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int WW        = 16,
    parameter int LED_TICKS = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] pulse_in,
    input  logic [WW-1:0]  width,
    input  logic [7:0]     holdoff,
    input  logic           clr_err,
    output logic [NCH-1:0] pulse_out,
    output logic [NCH-1:0] led_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] overrun
);

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            stretch_channel #(
                .WW        (WW),
                .LED_TICKS (LED_TICKS)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .tick      (tick),
                .en        (ch_en[i]),
                .pulse_in  (pulse_in[i]),
                .width     (width),
                .holdoff   (holdoff),
                .clr_err   (clr_err),
                .pulse_out (pulse_out[i]),
                .led_out   (led_out[i]),
                .busy      (busy[i]),
                .overrun   (overrun[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gvizi_pulse_stretcher.sv
// Bench for gvizi_pulse_stretcher: vector table, pulse scoreboard
// and hand-written overrun / enable / LED / reset sequences.
`timescale 1ns/1ps
module tb_gvizi_pulse_stretcher;

    localparam int NCH = 4;
    localparam int WW  = 16;
    localparam int LT  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           tick;
    logic           clr_err;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] pulse_in;
    logic [WW-1:0]  width;
    logic [7:0]     holdoff;
    logic [NCH-1:0] pulse_out;
    logic [NCH-1:0] led_out;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] overrun;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic tick_on = 1'b0;
    int   tdiv = 0;

    typedef struct {
        int start;
        int len;
    } exp_t;

    typedef struct {
        int ch;
        int w;
        int h;
        int len;
        int bsy;
    } vec_t;

    exp_t exp_q[NCH][$];
    vec_t vecs[8];

    bit   hi[NCH];
    int   rise[NCH];
    int   plen[NCH];
    exp_t mon_e;

    int c, k, n;

    gvizi_pulse_stretcher #(
        .NCH       (NCH),
        .WW        (WW),
        .LED_TICKS (LT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .ch_en     (ch_en),
        .pulse_in  (pulse_in),
        .width     (width),
        .holdoff   (holdoff),
        .clr_err   (clr_err),
        .pulse_out (pulse_out),
        .led_out   (led_out),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                      name, act, req, cyc);
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi_lim);
        n_total++;
        if (act >= lo && act <= hi_lim) n_pass++;
        else $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)",
                      name, act, lo, hi_lim, cyc);
    endtask

    task automatic step(input int cnt);
        repeat (cnt) @(negedge clk);
    endtask

    task automatic expect_pulse(input int ch, input int start, input int len);
        exp_t e;
        e.start = start;
        e.len   = len;
        exp_q[ch].push_back(e);
    endtask

    function automatic int pending();
        int s = 0;
        for (int j = 0; j < NCH; j++) s += exp_q[j].size();
        return s;
    endfunction

    task automatic drain(input int budget);
        int t = 0;
        while ((pending() != 0 || busy != '0 || pulse_out != '0) && t < budget) begin
            step(1);
            t++;
        end
        if (t >= budget) begin
            n_total++;
            $display("FAIL drain_timeout: still pending after %0d cycles, required fewer",
                     t);
        end
    endtask

    // LED timebase strobe, one cycle in four
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = tick_on && (tdiv == 3);
            tdiv = (tdiv + 1) % 4;
        end
    end

    // Pulse monitor: measures each pulse and checks it against the queue
    always @(negedge clk) begin
        for (int j = 0; j < NCH; j++) begin
            if (pulse_out[j]) begin
                if (!hi[j]) begin
                    hi[j]   = 1'b1;
                    rise[j] = cyc;
                    plen[j] = 0;
                end
                plen[j]++;
            end else if (hi[j]) begin
                hi[j] = 1'b0;
                if (exp_q[j].size() == 0) begin
                    chk($sformatf("stray_pulse_ch%0d_len", j), plen[j], 0);
                end else begin
                    mon_e = exp_q[j].pop_front();
                    chk($sformatf("pulse_ch%0d_start", j), rise[j], mon_e.start);
                    chk($sformatf("pulse_ch%0d_len", j), plen[j], mon_e.len);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        clr_err  = 1'b0;
        ch_en    = '1;
        pulse_in = '0;
        width    = WW'(5);
        holdoff  = 8'd0;

        vecs[0] = '{0, 5,   0,   5,   5};
        vecs[1] = '{1, 3,   2,   3,   5};
        vecs[2] = '{2, 1,   0,   1,   1};
        vecs[3] = '{3, 0,   0,   1,   1};
        vecs[4] = '{0, 7,   3,   7,  10};
        vecs[5] = '{1, 0,   4,   1,   5};
        vecs[6] = '{2, 12, 255, 12, 267};
        vecs[7] = '{3, 2,   1,   2,   3};

        step(3);
        chk("rst_pulse_out", int'(pulse_out), 0);
        chk("rst_led_out", int'(led_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        step(4);

        for (int i = 0; i < 8; i++) begin
            c       = vecs[i].ch;
            width   = WW'(vecs[i].w);
            holdoff = 8'(vecs[i].h);
            k       = cyc;
            pulse_in[c] = 1'b1;
            expect_pulse(c, k + 3, vecs[i].len);
            step(2);
            pulse_in[c] = 1'b0;
            step(1);
            chk($sformatf("vec%0d_onehot", i), int'(pulse_out), 1 << c);
            n = 0;
            while (busy[c] && n < 1000) begin
                n++;
                step(1);
            end
            chk($sformatf("vec%0d_busy_cycles", i), n, vecs[i].bsy);
            drain(100);
        end

        // overrun while ACTIVE and HOLDOFF, clear, same-cycle set wins
        width   = WW'(10);
        holdoff = 8'd4;
        k       = cyc;
        pulse_in[0] = 1'b1;
        expect_pulse(0, k + 3, 10);
        step(2);
        pulse_in[0] = 1'b0;
        step(6);
        pulse_in[0] = 1'b1;
        step(2);
        pulse_in[0] = 1'b0;
        step(2);
        chk("ovr_active_set", int'(overrun[0]), 1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("ovr_cleared", int'(overrun[0]), 0);
        pulse_in[0] = 1'b1;
        step(2);
        pulse_in[0] = 1'b0;
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("ovr_set_beats_clr", int'(overrun[0]), 1);
        chk("ovr_busy_holdoff", int'(busy[0]), 1);
        step(1);
        chk("ovr_idle_after_holdoff", int'(busy[0]), 0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("ovr_cleared_again", int'(overrun[0]), 0);
        step(10);
        k = cyc;
        pulse_in[0] = 1'b1;
        expect_pulse(0, k + 3, 10);
        step(2);
        pulse_in[0] = 1'b0;
        drain(100);
        chk("ovr_after_accept", int'(overrun[0]), 0);

        // channel disable mid-pulse
        width   = WW'(20);
        holdoff = 8'd0;
        k       = cyc;
        pulse_in[2] = 1'b1;
        expect_pulse(2, k + 3, 6);
        step(2);
        pulse_in[2] = 1'b0;
        step(6);
        ch_en[2] = 1'b0;
        step(1);
        chk("dis_pulse_low", int'(pulse_out[2]), 0);
        chk("dis_busy_low", int'(busy[2]), 0);
        chk("dis_led_low", int'(led_out[2]), 0);
        pulse_in[2] = 1'b1;
        step(2);
        pulse_in[2] = 1'b0;
        step(3);
        chk("dis_no_overrun", int'(overrun[2]), 0);
        chk("dis_stays_idle", int'(busy[2]), 0);
        ch_en[2] = 1'b1;
        step(3);
        drain(100);

        // LED on-time and retrigger
        tick_on = 1'b1;
        step(40);
        chk("led_all_expired", int'(led_out), 0);
        width   = WW'(2);
        holdoff = 8'd0;
        k       = cyc;
        pulse_in[1] = 1'b1;
        expect_pulse(1, k + 3, 2);
        step(2);
        pulse_in[1] = 1'b0;
        step(1);
        chk("led_rise_with_pulse", int'(led_out[1]), 1);
        n = 0;
        while (led_out[1] && n < 200) begin
            n++;
            step(1);
        end
        chk_rng("led_on_cycles", n, 29, 32);
        step(5);
        k = cyc;
        pulse_in[1] = 1'b1;
        expect_pulse(1, k + 3, 2);
        n = 0;
        for (int t = 0; t < 200; t++) begin
            step(1);
            if (cyc == k + 2) pulse_in[1] = 1'b0;
            if (cyc == k + 20) begin
                pulse_in[1] = 1'b1;
                expect_pulse(1, k + 23, 2);
            end
            if (cyc == k + 22) pulse_in[1] = 1'b0;
            if (led_out[1]) n++;
            else if (cyc > k + 25) break;
        end
        chk_rng("led_retrig_cycles", n, 49, 52);
        tick_on = 1'b0;
        drain(100);

        // maximum width, width change mid-pulse must not matter
        width   = 16'hFFFF;
        holdoff = 8'd0;
        k       = cyc;
        pulse_in[1] = 1'b1;
        expect_pulse(1, k + 3, 65535);
        step(2);
        pulse_in[1] = 1'b0;
        step(8);
        width = WW'(3);
        drain(70000);

        // reset mid-pulse with input held high
        width   = WW'(30);
        holdoff = 8'd0;
        k       = cyc;
        pulse_in[0] = 1'b1;
        pulse_in[3] = 1'b1;
        expect_pulse(0, k + 3, 4);
        expect_pulse(3, k + 3, 4);
        step(2);
        pulse_in[0] = 1'b0;
        step(1);
        pulse_in[0] = 1'b1;
        step(3);
        chk("rst_pre_overrun", int'(overrun[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_pulse_out", int'(pulse_out), 0);
        chk("rstmid_led_out", int'(led_out), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_overrun", int'(overrun), 0);
        pulse_in[0] = 1'b0;
        step(2);
        reset = 1'b0;
        step(10);
        chk("rst_held_no_trig", int'(busy[3]), 0);
        pulse_in[3] = 1'b0;
        step(3);
        width = WW'(4);
        k     = cyc;
        pulse_in[3] = 1'b1;
        expect_pulse(3, k + 3, 4);
        step(2);
        pulse_in[3] = 1'b0;
        drain(100);

        chk("scoreboard_empty", pending(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
